// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search engine.
package sar_search_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } verdict_t;

  function automatic int sMin(input int w);
    return -(1 << (w - 1));
  endfunction

  function automatic int sMax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // One guard bit so lo can pass sMax and hi can pass sMin without wrapping.
  function automatic int bndW(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/sar_midpoint.sv
// Floor midpoint of two signed bounds; the sum is widened so lo+hi never wraps.
module sar_midpoint #(
  parameter int WIDTH = 4
) (
  input  logic signed [WIDTH:0] lo,
  input  logic signed [WIDTH:0] hi,
  output logic signed [WIDTH:0] mid
);

  logic signed [WIDTH+1:0] sum;

  assign sum = lo + hi;
  assign mid = (WIDTH + 1)'(sum >>> 1);

endmodule

// File: rtl/sar_search.sv
// Binary search of an external comparator's hidden operand via probe/verdict handshake.
// Optional SAR_SEARCH_ITER_COUNT_EN adds an iterCount output of consumed verdicts.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] probe,
  output logic             probeValid,
  input  logic             cmpValid,
  input  logic             aGtB,
  input  logic             aEqB,
  input  logic             aLtB,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic             protoErr
`ifdef SAR_SEARCH_ITER_COUNT_EN
  ,
  output logic [$clog2(WIDTH+2)-1:0] iterCount
`endif
);

  localparam int BW = bndW(WIDTH);
  localparam logic signed [BW-1:0] LO_INIT = BW'(sMin(WIDTH));
  localparam logic signed [BW-1:0] HI_INIT = BW'(sMax(WIDTH));

  state_t               state;
  logic signed [BW-1:0] lo, hi, mid, loNext, hiNext;
  verdict_t             v;
  logic                 oneHot;
  logic                 accept;

  sar_midpoint #(.WIDTH(WIDTH)) uMid (
    .lo (lo),
    .hi (hi),
    .mid(mid)
  );

  assign probe  = WIDTH'(mid);
  assign v      = '{gt: aGtB, eq: aEqB, lt: aLtB};
  assign oneHot = $onehot(v);
  // done is high in the first IDLE cycle; a start there belongs to the old search.
  assign accept = (state == IDLE) && start && !done;

  always_comb begin
    loNext = lo;
    hiNext = hi;
    if (v.lt) loNext = mid + BW'(1);
    if (v.gt) hiNext = mid - BW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= IDLE;
      lo         <= '0;
      hi         <= '0;
      busy       <= 1'b0;
      probeValid <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      result     <= '0;
      protoErr   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= PROBE;
            lo         <= LO_INIT;
            hi         <= HI_INIT;
            busy       <= 1'b1;
            probeValid <= 1'b1;
            found      <= 1'b0;
            result     <= '0;
            protoErr   <= 1'b0;
          end
        end
        PROBE: begin
          if (cmpValid) begin
            if (!oneHot) begin
              state      <= IDLE;
              busy       <= 1'b0;
              probeValid <= 1'b0;
              done       <= 1'b1;
              found      <= 1'b0;
              result     <= '0;
              protoErr   <= 1'b1;
            end else if (v.eq) begin
              state      <= IDLE;
              busy       <= 1'b0;
              probeValid <= 1'b0;
              done       <= 1'b1;
              found      <= 1'b1;
              result     <= probe;
            end else begin
              lo <= loNext;
              hi <= hiNext;
              if (loNext > hiNext) begin
                state      <= IDLE;
                busy       <= 1'b0;
                probeValid <= 1'b0;
                done       <= 1'b1;
                found      <= 1'b0;
                result     <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SAR_SEARCH_ITER_COUNT_EN
  localparam int ITW = $clog2(WIDTH + 2);

  always_ff @(posedge clk) begin
    if (!rstN)                           iterCount <= '0;
    else if (accept)                     iterCount <= '0;
    else if (state == PROBE && cmpValid) iterCount <= iterCount + ITW'(1);
  end
`endif

endmodule
